rx_frame_builder: RTL and testbench

- Upstream feeder for the decoder path of `endec`.
- Collects a stream of received code symbols, one symbol per accepted cycle, into the 276-bit `i_decoder_data_frame` word consumed by `slice`.
- Frame holds 138 symbols at rate 1/2 (276 = 138×2) or 92 symbols at rate 1/3 (276 = 92×3).
- Double-buffered (fill register plus output register), so symbol intake continues while the decoder holds the previous frame.

---
 rtl/rx_frame_builder_pkg.sv | 15 +
 rtl/rx_frame_outreg.sv | 39 +++
 rtl/rx_frame_builder.sv | 159 +++++++++++++++
 tb/tb_rx_frame_builder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_builder_pkg.sv
// rx_frame_builder_pkg: frame geometry constants and fill-state encoding
// shared by the rx frame builder and its output register.
package rx_frame_builder_pkg;

  localparam int RX_FRAME_W = 276;
  localparam int RX_SYMS_R2 = 138;
  localparam int RX_SYMS_R3 = 92;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT
  } fill_state_t;

endpackage

// File: rtl/rx_frame_outreg.sv
// rx_frame_outreg: output stage of the rx frame builder. Holds one complete
// frame plus its code rate and runs the valid/ready handshake toward the
// decoder. A load is only requested when the register is free, so the held
// frame never changes while it is valid and not being taken.
module rx_frame_outreg #(
  parameter int FRAME_W = 276
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic               load_rate,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               frame_rate
);

  // Capture a new frame on load, otherwise drop valid once the consumer takes it.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_rate  <= 1'b0;
    end else if (clear) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_rate  <= 1'b0;
    end else if (load) begin
      frame       <= load_frame;
      frame_valid <= 1'b1;
      frame_rate  <= load_rate;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_builder.sv
// rx_frame_builder: packs received code symbols MSB-first into the 276-bit
// decoder frame (138 x 2 bits at rate 1/2, 92 x 3 bits at rate 1/3).
// Double-buffered: the fill register keeps collecting while the output
// register holds the previous frame for the decoder.
// Optional build macro RX_FRAME_FLUSH_EN adds i_flush, which closes a partly
// filled frame early with the remaining slots left at zero.
module rx_frame_builder
  import rx_frame_builder_pkg::*;
#(
  parameter int FRAME_W = RX_FRAME_W,
  parameter int SYM_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_code_rate,
  input  logic [SYM_W-1:0]   i_sym,
  input  logic               i_sym_valid,
  output logic               o_sym_ready,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_frame_valid,
  input  logic               i_frame_ready,
`ifdef RX_FRAME_FLUSH_EN
  input  logic               i_flush,
`endif
  output logic               o_frame_rate
);

  fill_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rate_q, rate_d;
  logic [FRAME_W-1:0] fill_q, fill_d;

  logic               accept;
  logic               eff_rate;
  logic [CNT_W-1:0]   n_syms;
  logic               last_sym;
  logic               flush_req;
  logic               complete;
  logic               out_free;
  logic               load;
  logic [CNT_W+1:0]   shift_amt;
  logic [FRAME_W-1:0] sym_slot;
  logic [FRAME_W-1:0] merged;
  logic [FRAME_W-1:0] load_frame;

  // Ready is forced low while reset is held and while a finished frame waits
  // for the output register.
  assign o_sym_ready = rst && (state_q != WAIT);
  assign accept      = i_sym_valid && o_sym_ready;
  assign out_free    = !o_frame_valid || i_frame_ready;

  // The first symbol of a frame already uses the incoming rate for its slot.
  assign eff_rate  = (state_q == IDLE) ? i_code_rate : rate_q;
  assign n_syms    = rate_q ? CNT_W'(RX_SYMS_R3) : CNT_W'(RX_SYMS_R2);
  assign last_sym  = (count_q == n_syms - 1'b1);

  // Slot k starts 2k (rate 1/2) or 3k (rate 1/3) bits below the frame MSB.
  assign shift_amt = eff_rate ? ({2'b00, count_q} + {1'b0, count_q, 1'b0})
                              : {1'b0, count_q, 1'b0};
  assign sym_slot  = eff_rate ? ({i_sym, {(FRAME_W-SYM_W){1'b0}}} >> shift_amt)
                              : ({i_sym[1:0], {(FRAME_W-2){1'b0}}} >> shift_amt);
  assign merged    = accept ? (fill_q | sym_slot) : fill_q;

`ifdef RX_FRAME_FLUSH_EN
  assign flush_req = i_flush && (state_q == FILL);
`else
  assign flush_req = 1'b0;
`endif

  assign complete   = (state_q == FILL) && ((accept && last_sym) || flush_req);
  assign load_frame = (state_q == WAIT) ? fill_q : merged;

  // Fill FSM: decide the next fill state and whether the output register loads.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rate_d  = rate_q;
    fill_d  = fill_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rate_d  = i_code_rate;
          fill_d  = merged;
          count_d = CNT_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (complete) begin
          count_d = '0;
          if (out_free) begin
            load    = 1'b1;
            fill_d  = '0;
            state_d = IDLE;
          end else begin
            fill_d  = merged;
            state_d = WAIT;
          end
        end else if (accept) begin
          fill_d  = merged;
          count_d = count_q + 1'b1;
        end
      end
      WAIT: begin
        if (out_free) begin
          load    = 1'b1;
          fill_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        fill_d  = '0;
      end
    endcase
    if (i_clear) begin
      state_d = IDLE;
      count_d = '0;
      rate_d  = 1'b0;
      fill_d  = '0;
      load    = 1'b0;
    end
  end

  // Fill-side state register.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rate_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rate_q  <= rate_d;
      fill_q  <= fill_d;
    end
  end

  rx_frame_outreg #(
    .FRAME_W(FRAME_W)
  ) u_outreg (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .clear      (i_clear),
    .load       (load),
    .load_frame (load_frame),
    .load_rate  (rate_q),
    .frame_ready(i_frame_ready),
    .frame      (o_frame),
    .frame_valid(o_frame_valid),
    .frame_rate (o_frame_rate)
  );

endmodule

// File: tb/tb_rx_frame_builder.sv
// tb_rx_frame_builder: directed bench for rx_frame_builder. Expected frames
// are built by the bench from the symbol patterns it sends.
module tb_rx_frame_builder;

  localparam int FW    = 276;
  localparam int GUARD = 1000;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          i_clear;
  logic          i_code_rate;
  logic [2:0]    i_sym;
  logic          i_sym_valid;
  logic          o_sym_ready;
  logic [FW-1:0] o_frame;
  logic          o_frame_valid;
  logic          i_frame_ready;
  logic          o_frame_rate;
`ifdef RX_FRAME_FLUSH_EN
  logic          i_flush;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [FW-1:0] exp_k3;
  logic [FW-1:0] exp_frame;
  logic [FW-1:0] frame_a;
  logic [FW-1:0] frame_b;
  logic          ready_dropped;

  rx_frame_builder dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_code_rate  (i_code_rate),
    .i_sym        (i_sym),
    .i_sym_valid  (i_sym_valid),
    .o_sym_ready  (o_sym_ready),
    .o_frame      (o_frame),
    .o_frame_valid(o_frame_valid),
    .i_frame_ready(i_frame_ready),
`ifdef RX_FRAME_FLUSH_EN
    .i_flush      (i_flush),
`endif
    .o_frame_rate (o_frame_rate)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_output(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one symbol and hold it until the block accepts it.
  task automatic apply_stimulus(input logic [2:0] s);
    int guard = 0;
    i_sym       = s;
    i_sym_valid = 1'b1;
    while (!o_sym_ready && guard < GUARD) begin
      step();
      guard++;
    end
    step();
    i_sym_valid = 1'b0;
    if (guard >= GUARD) check_output("sym_accept_timeout", 0, 1);
  endtask

  initial begin
    rst           = 1'b0;
    i_clear       = 1'b0;
    i_code_rate   = 1'b0;
    i_sym         = 3'b000;
    i_sym_valid   = 1'b0;
    i_frame_ready = 1'b0;
`ifdef RX_FRAME_FLUSH_EN
    i_flush       = 1'b0;
`endif

    exp_k3 = '0;
    for (int k = 0; k < 138; k++) exp_k3[275-2*k -: 2] = 2'(k & 3);

    // Reset state
    repeat (3) step();
    check_output("rst_frame", o_frame, 0);
    check_output("rst_valid", o_frame_valid, 0);
    check_output("rst_rate", o_frame_rate, 0);
    check_output("rst_ready", o_sym_ready, 0);
    rst = 1'b1;
    #1;
    check_output("ready_after_release", o_sym_ready, 1);
    step();

    // Rate 1/2 packing, consumer always ready
    $display("[TB] rate 1/2 packing");
    i_frame_ready = 1'b1;
    i_code_rate   = 1'b0;
    ready_dropped = 1'b0;
    for (int k = 0; k < 138; k++) begin
      apply_stimulus(3'(k & 3));
      if (!o_sym_ready) ready_dropped = 1'b1;
    end
    check_output("r2_valid", o_frame_valid, 1);
    check_output("r2_frame", o_frame, exp_k3);
    check_output("r2_msb_slot", o_frame[275:274], 2'b00);
    check_output("r2_slot1", o_frame[273:272], 2'b01);
    check_output("r2_last_slot", o_frame[1:0], 2'b01);
    check_output("r2_rate", o_frame_rate, 0);
    check_output("r2_ready_dropped", ready_dropped, 0);
    step();
    check_output("r2_valid_drop", o_frame_valid, 0);

    // Rate 1/3 packing
    $display("[TB] rate 1/3 packing");
    i_code_rate = 1'b1;
    for (int k = 0; k < 92; k++) apply_stimulus(3'b101);
    exp_frame = {92{3'b101}};
    check_output("r3_valid", o_frame_valid, 1);
    check_output("r3_frame", o_frame, exp_frame);
    check_output("r3_rate", o_frame_rate, 1);
    step();

    // Backpressure: two frames with the consumer stalled
    $display("[TB] backpressure");
    i_frame_ready = 1'b0;
    i_code_rate   = 1'b0;
    frame_a = {138{2'b10}};
    frame_b = {138{2'b01}};
    for (int k = 0; k < 138; k++) apply_stimulus(3'b010);
    check_output("bp_a_valid", o_frame_valid, 1);
    check_output("bp_a_frame", o_frame, frame_a);
    for (int k = 0; k < 138; k++) apply_stimulus(3'b001);
    check_output("bp_wait_ready", o_sym_ready, 0);
    check_output("bp_a_held", o_frame, frame_a);
    repeat (3) step();
    check_output("bp_a_still_held", o_frame, frame_a);
    check_output("bp_a_still_valid", o_frame_valid, 1);
    check_output("bp_still_wait", o_sym_ready, 0);
    i_frame_ready = 1'b1;
    step();
    i_frame_ready = 1'b0;
    check_output("bp_b_frame", o_frame, frame_b);
    check_output("bp_b_valid", o_frame_valid, 1);
    check_output("bp_ready_back", o_sym_ready, 1);
    step();
    check_output("bp_b_held", o_frame, frame_b);
    i_frame_ready = 1'b1;
    step();
    check_output("bp_b_consumed", o_frame_valid, 0);

    // Rate change mid-frame is ignored until the next frame
    $display("[TB] rate change mid-frame");
    i_code_rate = 1'b0;
    for (int k = 0; k < 10; k++) apply_stimulus(3'b111);
    i_code_rate = 1'b1;
    for (int k = 0; k < 127; k++) apply_stimulus(3'b111);
    check_output("rc_not_early", o_frame_valid, 0);
    apply_stimulus(3'b111);
    exp_frame = '1;
    check_output("rc_valid", o_frame_valid, 1);
    check_output("rc_frame", o_frame, exp_frame);
    check_output("rc_rate", o_frame_rate, 0);
    for (int k = 0; k < 92; k++) apply_stimulus(3'b110);
    exp_frame = {92{3'b110}};
    check_output("rc_next_frame", o_frame, exp_frame);
    check_output("rc_next_rate", o_frame_rate, 1);
    step();

    // Reset mid-frame with a frame held at the output
    $display("[TB] reset mid-frame");
    i_frame_ready = 1'b0;
    i_code_rate   = 1'b1;
    for (int k = 0; k < 92; k++) apply_stimulus(3'b111);
    i_code_rate = 1'b0;
    for (int k = 0; k < 50; k++) apply_stimulus(3'b010);
    rst = 1'b0;
    #1;
    check_output("mrst_frame", o_frame, 0);
    check_output("mrst_valid", o_frame_valid, 0);
    check_output("mrst_rate", o_frame_rate, 0);
    check_output("mrst_ready", o_sym_ready, 0);
    step();
    rst = 1'b1;
    step();
    i_frame_ready = 1'b1;
    for (int k = 0; k < 138; k++) apply_stimulus(3'(k & 3));
    check_output("mrst_fresh_valid", o_frame_valid, 1);
    check_output("mrst_fresh_frame", o_frame, exp_k3);
    step();

    // Soft clear mid-frame, colliding with a symbol offer
    $display("[TB] clear mid-frame");
    i_frame_ready = 1'b0;
    i_code_rate   = 1'b1;
    for (int k = 0; k < 92; k++) apply_stimulus(3'b111);
    i_code_rate = 1'b0;
    for (int k = 0; k < 50; k++) apply_stimulus(3'b010);
    i_clear     = 1'b1;
    i_sym       = 3'b111;
    i_sym_valid = 1'b1;
    step();
    i_clear     = 1'b0;
    i_sym_valid = 1'b0;
    check_output("clr_frame", o_frame, 0);
    check_output("clr_valid", o_frame_valid, 0);
    check_output("clr_rate", o_frame_rate, 0);
    check_output("clr_ready", o_sym_ready, 1);
    i_frame_ready = 1'b1;
    for (int k = 0; k < 138; k++) apply_stimulus(3'(k & 3));
    check_output("clr_fresh_valid", o_frame_valid, 1);
    check_output("clr_fresh_frame", o_frame, exp_k3);
    step();

`ifdef RX_FRAME_FLUSH_EN
    // Early flush pads the tail with zeros
    $display("[TB] flush");
    i_code_rate = 1'b0;
    for (int k = 0; k < 130; k++) apply_stimulus(3'b011);
    check_output("fl_not_yet", o_frame_valid, 0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    exp_frame = '1;
    exp_frame[15:0] = 16'h0000;
    check_output("fl_valid", o_frame_valid, 1);
    check_output("fl_frame", o_frame, exp_frame);
    step();
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
